// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Sends one 8-bit word per accepted request as
// start / 8 data bits (LSB first) / optional parity / 1 stop bit, each bit held
// for Prescale CLK cycles (0 is treated as 1).
// Build option: define UART_TX_PARITY_EN to include the parity bit; otherwise
// PAR_EN/PAR_TYP are ignored and every frame is 10 bits.
module uart_tx_frame (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  output logic       TX_OUT,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q,   cnt_d;
  logic [2:0] idx_q,   idx_d;
  logic [7:0] data_q,  data_d;
  logic [5:0] pre_q,   pre_d;
  logic       tx_q,    tx_d;
  logic       busy_q,  busy_d;
  logic       bit_end;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_q,    par_d;
`else
  // Parity inputs stay on the port list but have no function in this build.
  logic       unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  // State, counters, latched frame and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      pre_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      pre_q    <= pre_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

  // Next-state logic, bit timer, and output decode from the next state so the
  // line changes on the same edge as the state.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 6'd1;
    idx_d    = idx_q;
    data_d   = data_q;
    pre_d    = pre_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif
    bit_end  = (cnt_q == pre_q - 6'd1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (Data_Valid) begin
          data_d   = P_DATA;
          pre_d    = (Prescale == 6'd0) ? 6'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
          par_en_d = PAR_EN;
          par_d    = (^P_DATA) ^ PAR_TYP;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    unique case (state_d)
      S_IDLE:   begin tx_d = 1'b1;          busy_d = 1'b0; end
      S_START:  begin tx_d = 1'b0;          busy_d = 1'b1; end
      S_DATA:   begin tx_d = data_d[idx_d]; busy_d = 1'b1; end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin tx_d = par_d;         busy_d = 1'b1; end
`endif
      S_STOP:   begin tx_d = 1'b1;          busy_d = 1'b1; end
      default:  begin tx_d = 1'b1;          busy_d = 1'b0; end
    endcase
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: frame-level reference model checked every cycle,
// plus literal bit sequences and Busy lengths for directed frames.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = '0;
  logic       TX_OUT;
  logic       Busy;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_frame dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: frame as a list of bits ----------------
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pe,
                                             input logic pt);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    if (pe) b[9] = (^d) ^ pt;
`else
    b[9] = 1'b1 | pe | pt;
`endif
    return b;
  endfunction

  function automatic int frame_len(input logic pe);
`ifdef UART_TX_PARITY_EN
    return pe ? 11 : 10;
`else
    return pe ? 10 : 10;
`endif
  endfunction

  logic        m_active = 1'b0;
  int          m_elapsed = 0;
  int          m_p = 1;
  int          m_nbits = 10;
  logic [10:0] m_bits = '1;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_active  <= 1'b0;
      m_elapsed <= 0;
    end else if (m_active) begin
      if (m_elapsed + 1 == m_nbits * m_p) m_active <= 1'b0;
      else m_elapsed <= m_elapsed + 1;
    end else if (Data_Valid) begin
      m_active  <= 1'b1;
      m_elapsed <= 0;
      m_p       <= (Prescale == 6'd0) ? 1 : int'(Prescale);
      m_bits    <= frame_bits(P_DATA, PAR_EN, PAR_TYP);
      m_nbits   <= frame_len(PAR_EN);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    check("tx_line", int'(TX_OUT), m_active ? int'(m_bits[m_elapsed / m_p]) : 1);
    check("busy",    int'(Busy),   m_active ? 1 : 0);
  end

  // ---------------- stimulus helpers ----------------
  bit smp[$];

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic [5:0] p, input logic pe,
                      input logic pt);
    P_DATA = d; Prescale = p; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // Collect TX_OUT for every cycle Busy is high; returns the count.
  task automatic collect(output int cycles);
    smp.delete();
    cycles = 0;
    forever begin
      @(negedge CLK);
      if (!Busy) break;
      smp.push_back(TX_OUT);
      cycles++;
      if (cycles > 2000) begin
        check("busy_timeout", cycles, 0);
        break;
      end
    end
  endtask

  // seq is written in transmit order: the leftmost of n bits goes first.
  task automatic check_frame(input string name, input logic [10:0] seq, input int n,
                             input int p, input int cycles);
    check({name, "_busy_len"}, cycles, n * p);
    for (int j = 0; j < n; j++) begin
      int got;
      got = int'(seq[n-1-j]);
      for (int c = 0; c < p; c++) begin
        int idx = j * p + c;
        if (idx >= smp.size()) got = int'(!seq[n-1-j]);
        else if (smp[idx] != seq[n-1-j]) got = int'(smp[idx]);
      end
      check($sformatf("%s_bit%0d", name, j), got, int'(seq[n-1-j]));
    end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int idle;

    // Reset state.
    repeat (2) tick();
    check("reset_tx", int'(TX_OUT), 1);
    check("reset_busy", int'(Busy), 0);
    RST = 1'b1;
    repeat (2) tick();

    // 0xA5, P=8, even parity.
    send(8'hA5, 6'd8, 1'b1, 1'b0);
    collect(cyc);
`ifdef UART_TX_PARITY_EN
    check_frame("a5_even", 11'b01010010101, 11, 8, cyc);
`else
    check_frame("a5_even", 11'b0101001011, 10, 8, cyc);
`endif
    tick();

    // 0x00, P=8, odd parity.
    send(8'h00, 6'd8, 1'b1, 1'b1);
    collect(cyc);
`ifdef UART_TX_PARITY_EN
    check_frame("00_odd", 11'b00000000011, 11, 8, cyc);
`else
    check_frame("00_odd", 11'b0000000001, 10, 8, cyc);
`endif
    tick();

    // 0xFF at P=1, then P=0 (treated as 1).
    send(8'hFF, 6'd1, 1'b0, 1'b0);
    collect(cyc);
    check_frame("ff_p1", 11'b0111111111, 10, 1, cyc);
    tick();
    send(8'hFF, 6'd0, 1'b0, 1'b0);
    collect(cyc);
    check_frame("ff_p0", 11'b0111111111, 10, 1, cyc);
    tick();

    // 0x81 with a 0x3C request mid-frame, then Data_Valid held high.
    send(8'h81, 6'd8, 1'b0, 1'b0);
    fork
      collect(cyc);
      begin
        repeat (19) tick();
        P_DATA = 8'h3C; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; P_DATA = 8'h81;
        repeat (20) tick();
        P_DATA = 8'h3C; Prescale = 6'd2; PAR_EN = 1'b0; Data_Valid = 1'b1;
      end
    join
    check_frame("81_ignore", 11'b0100000011, 10, 8, cyc);
    idle = 1;
    while (idle < 100) begin
      @(negedge CLK);
      if (Busy) break;
      idle++;
    end
    Data_Valid = 1'b0;
    check("b2b_gap", idle, 1);
    collect(cyc);
    check("b2b_len", cyc + 1, 20);
    tick();

    // Reset mid-frame at cycle 30, then a clean frame.
    send(8'h5A, 6'd8, 1'b0, 1'b0);
    repeat (29) tick();
    RST = 1'b0;
    #1;
    check("midrst_tx", int'(TX_OUT), 1);
    check("midrst_busy", int'(Busy), 0);
    repeat (2) tick();
    RST = 1'b1;
    tick();
    send(8'hC3, 6'd3, 1'b0, 1'b0);
    collect(cyc);
    check_frame("c3_after_rst", 11'b0110000111, 10, 3, cyc);
    tick();

    // 0x55, P=4, parity requested.
    send(8'h55, 6'd4, 1'b1, 1'b0);
    collect(cyc);
`ifdef UART_TX_PARITY_EN
    check_frame("55_p4", 11'b01010101001, 11, 4, cyc);
`else
    check_frame("55_p4", 11'b0101010101, 10, 4, cyc);
`endif
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
